seg_display_scanner: RTL and testbench

Parametrised successor to the CPU debug-display data selector. Selects one of NUM_SRC packed hex debug words (PC, register, ALU, bus values), latches it frame-coherently, and time-multiplexes DIGITS 7-segment digits from an internal refresh prescaler. Adds anti-ghost blanking, leading-zero suppression, hold/freeze and per-digit decimal points. Sits between the CPU debug buses / board switches and the board seven-segment pins.

---
 rtl/seg_display_scanner.sv | 154 +++++++++++++++
 tb/tb_seg_display_scanner.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scanner.sv
// Multiplexed seven-segment scanner for CPU debug words: frame-coherent source
// snapshot, anti-ghost blank window, leading-zero blanking and per-digit points.
module seg_display_scanner #(
  parameter int DIGITS    = 8,
  parameter int NUM_SRC   = 4,
  parameter int SEL_W     = 2,
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 2000
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic [SEL_W-1:0]              sel,
  input  logic [NUM_SRC*DIGITS*4-1:0]   src_data,
  input  logic [DIGITS-1:0]             dp_in,
  input  logic                          hold,
  input  logic                          lzb,
  output logic [DIGITS-1:0]             an,
  output logic [6:0]                    seg,
  output logic                          dp_n,
  output logic                          frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int WW = DIGITS * 4;

  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
  localparam logic [IW-1:0] DIG_LAST  = IW'(DIGITS - 1);
  localparam logic [6:0]    SEG_OFF   = 7'h7F;

  logic [PW-1:0]     prescaler_q, prescaler_d;
  logic [IW-1:0]     digit_idx_q, digit_idx_d;
  logic [WW-1:0]     snapshot_q,  snapshot_d;
  logic [DIGITS-1:0] an_q,        an_d;
  logic [6:0]        seg_q,       seg_d;
  logic              dp_n_q,      dp_n_d;
  logic              frame_done_q, frame_done_d;

  logic              tick;
  logic              frame_end;
  logic              blank_win;
  logic [WW-1:0]     src_word;
  logic [DIGITS:0]   zero_from;
  logic [3:0]        cur_nibble;
  logic              cur_blank;
  logic              cur_dp;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    hex_to_seg = 7'b1000000;
      4'h1:    hex_to_seg = 7'b1111001;
      4'h2:    hex_to_seg = 7'b0100100;
      4'h3:    hex_to_seg = 7'b0110000;
      4'h4:    hex_to_seg = 7'b0011001;
      4'h5:    hex_to_seg = 7'b0010010;
      4'h6:    hex_to_seg = 7'b0000010;
      4'h7:    hex_to_seg = 7'b1111000;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0010000;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b0000011;
      4'hC:    hex_to_seg = 7'b1000110;
      4'hD:    hex_to_seg = 7'b0100001;
      4'hE:    hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // Scan timing and frame-coherent source capture.
  always_comb begin
    tick        = (prescaler_q == PRE_LAST);
    frame_end   = tick && (digit_idx_q == DIG_LAST);
    prescaler_d = tick ? '0 : prescaler_q + PW'(1);
    digit_idx_d = digit_idx_q;
    if (tick) begin
      digit_idx_d = (digit_idx_q == DIG_LAST) ? '0 : digit_idx_q + IW'(1);
    end

    // Out-of-range selects fall through to the all-zero default.
    src_word = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        src_word = src_data[k*WW +: WW];
      end
    end
    snapshot_d = (frame_end && !hold) ? src_word : snapshot_q;
  end

  // Digit content: zero_from[d] is set when nibbles d..DIGITS-1 are all zero.
  always_comb begin
    zero_from[DIGITS] = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      zero_from[d] = zero_from[d+1] && (snapshot_q[d*4 +: 4] == 4'h0);
    end

    cur_nibble = 4'h0;
    cur_blank  = 1'b0;
    cur_dp     = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (digit_idx_q == IW'(d)) begin
        cur_nibble = snapshot_q[d*4 +: 4];
        cur_blank  = lzb && (d != 0) && zero_from[d];
        cur_dp     = dp_in[d];
      end
    end
  end

  // Output drive is computed from current state and registered next edge.
  always_comb begin
    blank_win    = (prescaler_q < BLANK_END);
    frame_done_d = frame_end;
    an_d         = '1;
    seg_d        = SEG_OFF;
    dp_n_d       = 1'b1;
    if (!blank_win) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (digit_idx_q == IW'(d)) begin
          an_d[d] = 1'b0;
        end
      end
      seg_d  = cur_blank ? SEG_OFF : hex_to_seg(cur_nibble);
      dp_n_d = ~cur_dp;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      prescaler_q  <= '0;
      digit_idx_q  <= '0;
      snapshot_q   <= '0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      digit_idx_q  <= digit_idx_d;
      snapshot_q   <= snapshot_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner: directed scenarios plus random
// stimulus against a time-index reference model of the scan.
module tb_seg_display_scanner;

  localparam int DIGITS    = 4;
  localparam int NUM_SRC   = 3;
  localparam int SEL_W     = 2;
  localparam int CLK_DIV   = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = DIGITS * CLK_DIV;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic                        CLK = 1'b0;
  logic                        Reset;
  logic [SEL_W-1:0]            sel;
  logic [NUM_SRC*DIGITS*4-1:0] src_data;
  logic [DIGITS-1:0]           dp_in;
  logic                        hold;
  logic                        lzb;
  logic [DIGITS-1:0]           an;
  logic [6:0]                  seg;
  logic                        dp_n;
  logic                        frame_done;

  int errors = 0;
  int checks = 0;

  // Reference model: t counts cycles of scan state since the last reset.
  int                   t = 0;
  logic [DIGITS*4-1:0]  snap = '0;
  logic [12:0]          exp_out;

  seg_display_scanner #(
    .DIGITS(DIGITS), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W),
    .CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .CLK(CLK), .Reset(Reset), .sel(sel), .src_data(src_data), .dp_in(dp_in),
    .hold(hold), .lzb(lzb), .an(an), .seg(seg), .dp_n(dp_n), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // One clock edge; the model predicts what the outputs show after it.
  task automatic step();
    int p, d, nib, s;
    logic [DIGITS-1:0] e_an;
    logic [6:0]        e_seg;
    logic              e_dp, e_fd;
    @(posedge CLK);
    if (!Reset) begin
      t = 0;
      snap = '0;
      exp_out = {4'hF, 7'h7F, 1'b1, 1'b0};
    end else begin
      p     = t % CLK_DIV;
      d     = (t / CLK_DIV) % DIGITS;
      e_fd  = (p == CLK_DIV - 1) && (d == DIGITS - 1);
      e_an  = '1;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (p >= BLANK_CYC) begin
        e_an[d] = 1'b0;
        nib = int'((snap >> (4 * d)) & 16'hF);
        if (!(lzb && d != 0 && (snap >> (4 * d)) == 0)) e_seg = HEX_SEG[nib];
        e_dp = ~dp_in[d];
      end
      exp_out = {e_an, e_seg, e_dp, e_fd};
      if (e_fd && !hold) begin
        s = int'(sel);
        snap = (s < NUM_SRC) ? src_data[s*DIGITS*4 +: DIGITS*4] : '0;
      end
      t++;
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; sel = '0; hold = 1'b0; lzb = 1'b0; dp_in = '0;
    src_data = {16'h0000, 16'h0005, 16'h12AF};
    repeat (2) begin
      step();
      if ({an, seg, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_state: got %b want %b", {an, seg, dp_n, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
      checks++;
    end
  endtask

  task automatic test_basic_scan();
    logic [3:0] an_seq  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_seq [4] = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    int fd_count = 0;
    int s, c;
    Reset = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if ({an, seg, dp_n, frame_done} !== exp_out) begin
        errors++;
        $display("FAIL basic_model t=%0d: got %b want %b", t, {an, seg, dp_n, frame_done}, exp_out);
      end
      checks++;
      if (frame_done) fd_count++;
      if (i >= FRAME) begin
        s = (i - FRAME) / CLK_DIV;
        c = i % CLK_DIV;
        if (c == 0 && an !== 4'b1111) begin
          errors++;
          $display("FAIL basic_blank slot=%0d: got an=%b want 1111", s, an);
        end
        if (c != 0 && (an !== an_seq[s] || seg !== seg_seq[s])) begin
          errors++;
          $display("FAIL basic_digit slot=%0d: got an=%b seg=%b want an=%b seg=%b", s, an, seg, an_seq[s], seg_seq[s]);
        end
        checks++;
      end
    end
    if (fd_count !== 2) begin
      errors++;
      $display("FAIL frame_done_count: got %0d want 2", fd_count);
    end
    checks++;
  endtask

  task automatic test_reset_mid_slot();
    while (t % FRAME != 2 * CLK_DIV + 2) begin
      step();
      if ({an, seg, dp_n, frame_done} !== exp_out) begin
        errors++;
        $display("FAIL midreset_model t=%0d: got %b want %b", t, {an, seg, dp_n, frame_done}, exp_out);
      end
      checks++;
    end
    Reset = 1'b0;
    step();
    if ({an, seg, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midreset_abort: got %b want %b", {an, seg, dp_n, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    checks++;
    Reset = 1'b1;
    step();
    if ({an, seg, dp_n} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL midreset_blank: got %b want %b", {an, seg, dp_n}, {4'hF, 7'h7F, 1'b1});
    end
    checks++;
    step();
    if ({an, seg} !== {4'b1110, 7'b1000000}) begin
      errors++;
      $display("FAIL midreset_first_digit: got an=%b seg=%b want an=1110 seg=1000000", an, seg);
    end
    checks++;
  endtask

  task automatic test_tearing();
    sel = 2'd0;
    while (t % FRAME != 0) step();
    repeat (FRAME) step();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == 6) sel = 2'd1;
      step();
      if ({an, seg, dp_n, frame_done} !== exp_out) begin
        errors++;
        $display("FAIL tear_model t=%0d: got %b want %b", t, {an, seg, dp_n, frame_done}, exp_out);
      end
      checks++;
      if (i == 13 && seg !== 7'b1111001) begin
        errors++;
        $display("FAIL tear_old_frame: got seg=%b want 1111001", seg);
      end
      if (i == FRAME + 1 && seg !== 7'b0010010) begin
        errors++;
        $display("FAIL tear_new_digit0: got seg=%b want 0010010", seg);
      end
      if (i == FRAME + 13 && seg !== 7'b1000000) begin
        errors++;
        $display("FAIL tear_new_digit3: got seg=%b want 1000000", seg);
      end
      if (i == 13 || i == FRAME + 1 || i == FRAME + 13) checks++;
    end
  endtask

  task automatic test_hold_lzb();
    hold = 1'b1; sel = 2'd0;
    src_data[15:0] = 16'hBEEF;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if ({an, seg, dp_n, frame_done} !== exp_out) begin
        errors++;
        $display("FAIL hold_model t=%0d: got %b want %b", t, {an, seg, dp_n, frame_done}, exp_out);
      end
      checks++;
      if (i % FRAME == 1) begin
        if (seg !== 7'b0010010) begin
          errors++;
          $display("FAIL hold_frozen: got seg=%b want 0010010", seg);
        end
        checks++;
      end
    end
    hold = 1'b0; lzb = 1'b1; sel = 2'd1;
    for (int f = 0; f < 3; f++) begin
      if (f == 1) sel = 2'd2;
      for (int i = 0; i < FRAME; i++) begin
        step();
        if ({an, seg, dp_n, frame_done} !== exp_out) begin
          errors++;
          $display("FAIL lzb_model t=%0d: got %b want %b", t, {an, seg, dp_n, frame_done}, exp_out);
        end
        checks++;
        if (f != 1 && i % CLK_DIV == 1) begin
          if (i / CLK_DIV == 0) begin
            if (seg !== ((f == 0) ? 7'b0010010 : 7'b1000000)) begin
              errors++;
              $display("FAIL lzb_digit0 frame=%0d: got seg=%b", f, seg);
            end
          end else if (seg !== 7'h7F) begin
            errors++;
            $display("FAIL lzb_blanked digit=%0d: got seg=%b want 1111111", i / CLK_DIV, seg);
          end
          checks++;
        end
      end
    end
    lzb = 1'b0;
  endtask

  task automatic test_dp_range();
    int dp_low = 0;
    logic want_dp;
    dp_in = 4'b0100; sel = 2'd3;
    repeat (FRAME) step();
    for (int i = 0; i < FRAME; i++) begin
      step();
      want_dp = !((i / CLK_DIV == 2) && (i % CLK_DIV != 0));
      if ({an, seg, dp_n, frame_done} !== exp_out) begin
        errors++;
        $display("FAIL dp_model t=%0d: got %b want %b", t, {an, seg, dp_n, frame_done}, exp_out);
      end
      if (dp_n !== want_dp) begin
        errors++;
        $display("FAIL dp_digit2 i=%0d: got dp_n=%b want %b", i, dp_n, want_dp);
      end
      if (i % CLK_DIV != 0 && seg !== 7'b1000000) begin
        errors++;
        $display("FAIL sel_out_of_range: got seg=%b want 1000000", seg);
      end
      checks++;
      if (dp_n === 1'b0) dp_low++;
    end
    if (dp_low !== CLK_DIV - BLANK_CYC) begin
      errors++;
      $display("FAIL dp_low_count: got %0d want %0d", dp_low, CLK_DIV - BLANK_CYC);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) sel = SEL_W'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)
        src_data = 48'({$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()});
      if ($urandom_range(0, 5) == 0) dp_in = DIGITS'($urandom());
      if ($urandom_range(0, 15) == 0) hold = ~hold;
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
      Reset = ($urandom_range(0, 149) != 0);
      step();
      if ({an, seg, dp_n, frame_done} !== exp_out) begin
        errors++;
        $display("FAIL random i=%0d t=%0d: got %b want %b", i, t, {an, seg, dp_n, frame_done}, exp_out);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_reset_mid_slot();
    test_tearing();
    test_hold_lzb();
    test_dp_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
